// File: rtl/square_if.sv
// square_if: start/busy/done handshake and operand/result bus of the squarer
interface square_if #(parameter int WIDTH = 32);
  logic             start;
  logic [WIDTH-1:0] val;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             ovf;
  modport master(output start, val, input busy, done, result, ovf);
  modport slave(input start, val, output busy, done, result, ovf);
endinterface

// File: rtl/square.sv
// square: iterative shift-add fixed-point squarer; define SQUARE_ROUND_EN for round-half-up
module square #(
  parameter int WIDTH = 32,
  parameter int FBITS = 16
) (
  input logic     clk,
  input logic     rst_n,
  square_if.slave s
);
  localparam int W2 = 2 * WIDTH;
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic {IDLE, CALC} state_t;
  state_t          state, state_nx;
  logic [W2-1:0]   mcand, acc, acc_nx;
  logic [WIDTH-1:0] mplier;
  logic [CW-1:0]   cnt;
  logic [W2:0]     p_adj, s_full;
  logic            last, sat, accept;
  assign accept = state == IDLE && s.start;
  assign last   = state == CALC && cnt == CW'(WIDTH - 1);
  assign sat    = |s_full[W2:WIDTH];
  always_comb begin
    state_nx = state == IDLE ? (s.start ? CALC : IDLE) : (last ? IDLE : CALC);
    acc_nx   = acc + (mplier[0] ? mcand : '0);
`ifdef SQUARE_ROUND_EN
    p_adj    = {1'b0, acc_nx} + ((W2 + 1)'(1) << (FBITS - 1));
`else
    p_adj    = {1'b0, acc_nx};
`endif
    s_full   = p_adj >> FBITS;
  end
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      mcand    <= '0;
      mplier   <= '0;
      acc      <= '0;
      cnt      <= '0;
      s.busy   <= 1'b0;
      s.done   <= 1'b0;
      s.result <= '0;
      s.ovf    <= 1'b0;
    end else begin
      state  <= state_nx;
      s.busy <= state_nx == CALC;
      s.done <= last;
      if (accept) begin
        mcand  <= {{WIDTH{1'b0}}, s.val};
        mplier <= s.val;
        acc    <= '0;
        cnt    <= '0;
      end else if (state == CALC) begin
        // multiplicand pre-shifted each cycle so it always sits at the counter position
        acc    <= acc_nx;
        mcand  <= mcand << 1;
        mplier <= mplier >> 1;
        cnt    <= cnt + 1'b1;
      end
      if (last) begin
        s.result <= sat ? '1 : s_full[WIDTH-1:0];
        s.ovf    <= sat;
      end
    end
  end
endmodule

// File: tb/tb_square.sv
// tb_square: random and directed checks of square against a timestamp-based reference model
module tb_square;
  localparam int W = 32;
  logic clk = 0;
  logic rst_n = 0;
  int n_chk = 0, n_pass = 0;
  square_if #(.WIDTH(W)) bus ();
  square #(.WIDTH(W), .FBITS(16)) dut (.clk(clk), .rst_n(rst_n), .s(bus));
  always #5 clk = ~clk;
  function automatic logic [32:0] model_sq(input logic [31:0] v);
    logic [64:0] p, q;
    p = 65'(v) * 65'(v);
`ifdef SQUARE_ROUND_EN
    p = p + (65'(1) << 15);
`endif
    q = p >> 16;
    return (q >= (65'(1) << 32)) ? {1'b1, 32'hFFFF_FFFF} : {1'b0, q[31:0]};
  endfunction
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    else n_pass++;
  endtask
  // reference: an operation accepted at edge c completes at edge c+32
  int cyc = 0, m_due = 0;
  logic m_en = 0, m_busy = 0, m_done = 0, m_ovf = 0;
  logic [31:0] m_pend = 0, m_res = 0;
  always @(posedge clk) begin
    cyc++;
    if (!rst_n) begin
      m_en = 1; m_busy = 0; m_done = 0; m_res = 0; m_ovf = 0;
    end else begin
      m_done = 0;
      if (m_busy && cyc == m_due) begin
        m_busy = 0; m_done = 1; {m_ovf, m_res} = model_sq(m_pend);
      end else if (!m_busy && bus.start) begin
        m_busy = 1; m_due = cyc + W; m_pend = bus.val;
      end
    end
  end
  always @(negedge clk) if (m_en) begin
    chk("busy", 32'(bus.busy), 32'(m_busy));
    chk("done", 32'(bus.done), 32'(m_done));
    chk("result", bus.result, m_res);
    chk("ovf", 32'(bus.ovf), 32'(m_ovf));
  end
  task automatic step();
    @(posedge clk); #2;
  endtask
  task automatic op(input logic [31:0] v, input logic [31:0] er, input logic eo, input bit poke, input string nm);
    int k;
    bus.start = 1; bus.val = v;
    step();
    bus.start = 0; bus.val = $urandom;
    step();
    for (k = 1; k < W + 10 && !bus.done; k++) begin
      if (poke && (k == 1 || k == 20)) begin bus.start = 1; bus.val = 32'h0003_0000; end
      step();
      bus.start = 0;
    end
    chk({nm, "_lat"}, 32'(k), 32'(W));
    chk({nm, "_res"}, bus.result, er);
    chk({nm, "_ovf"}, 32'(bus.ovf), 32'(eo));
    step();
  endtask
  initial begin
    int k, nd;
    bus.start = 0; bus.val = 0;
    repeat (3) step();
    rst_n = 1;
    step();
    chk("rst_busy", 32'(bus.busy), 0);
    chk("rst_done", 32'(bus.done), 0);
    chk("rst_result", bus.result, 0);
    chk("rst_ovf", 32'(bus.ovf), 0);
    op(32'h0002_0000, 32'h0004_0000, 0, 0, "two");
    op(32'h0001_8000, 32'h0002_4000, 0, 1, "onehalf_poke");
    op(32'h00FF_0000, 32'hFE01_0000, 0, 0, "x255");
    op(32'h0100_0000, 32'hFFFF_FFFF, 1, 0, "x256");
    op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 0, "allones");
`ifdef SQUARE_ROUND_EN
    op(32'h0000_00B6, 32'h0000_0001, 0, 0, "b6");
`else
    op(32'h0000_00B6, 32'h0000_0000, 0, 0, "b6");
`endif
    op(32'h0000_0100, 32'h0000_0001, 0, 0, "x100");
    op(32'h0000_0000, 32'h0000_0000, 0, 0, "zero");
    // abort by reset mid-operation
    bus.start = 1; bus.val = 32'h0002_0000;
    step();
    bus.start = 0;
    repeat (10) step();
    rst_n = 0;
    step();
    rst_n = 1;
    chk("abort_busy", 32'(bus.busy), 0);
    nd = 0;
    repeat (40) begin step(); nd += int'(bus.done); end
    chk("abort_nodone", 32'(nd), 0);
    // start held high: re-accepted on the done cycle, next done 33 cycles later
    bus.start = 1; bus.val = 32'h0002_0000;
    step();
    for (k = 0; k < 60 && !bus.done; k++) step();
    chk("hold_first", bus.result, 32'h0004_0000);
    bus.val = 32'h0000_0000;
    step();
    bus.val = $urandom;
    for (k = 1; k < 60 && !bus.done; k++) step();
    chk("hold_gap", 32'(k), 32'(W + 1));
    chk("hold_zero", bus.result, 32'h0);
    bus.start = 0;
    repeat (W + 2) step();
    // random traffic with occasional resets
    repeat (4000) begin
      bus.start = ($urandom % 3) == 0;
      bus.val = ($urandom % 8 == 0) ? 32'($urandom % 512) : ($urandom >> $urandom_range(0, 31));
      rst_n = ($urandom % 700) != 0;
      step();
    end
    rst_n = 1; bus.start = 0;
    repeat (W + 3) step();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
